if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC and selects the next PC from the controller's redirect outputs (pc_src, jump) and from pc_en.
- Drives a req/ack instruction-memory port that allows wait states.
- Feeds the IF/ID pipeline register, with stall (IF_ID_en) and flush (IF_flush) honoured.
- Includes a one-entry skid buffer for an instruction that returns while decode is stalled.

---
 rtl/if_stage_if.sv | 24 ++
 rtl/if_stage.sv | 162 ++++++++++++++++
 tb/tb_if_stage.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory port between the fetch stage and imem.
// req/addr go out, ack/rdata come back; wait states allowed.
interface if_stage_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/if_stage.sv
// Instruction fetch: PC select, imem req/ack, skid buffer, IF/ID register.
// A word returning under a decode stall waits in HOLD; redirects mid-fetch drain.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_en,
   input  logic        IF_ID_en,
   input  logic        IF_flush,
   input  logic        pc_src,
   input  logic [1:0]  jump,
   input  logic [31:0] branch_target,
   input  logic [31:0] jr_target,
   if_stage_if.master  imem,
   output logic [31:0] IF_ID_instr,
   output logic [31:0] IF_ID_pc_plus4,
   output logic        IF_ID_valid
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DRAIN,
      HOLD
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] buf_q, buf_d;
   logic        req_q, req_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   logic        redir;
   logic        deliver;
   logic        present;
   logic [31:0] word;
   logic [31:0] target;
   logic [31:0] pc_inc;

   assign redir   = pc_en & pc_src & (jump != 2'b11);
   assign deliver = pc_en & IF_ID_en & ~IF_flush;
   assign pc_inc  = pc_q + 32'd4;

   // j target is built from the instruction sitting in IF/ID
   always_comb begin
      unique case (jump)
         2'b00:   target = branch_target;
         2'b01:   target = {pc4_q[31:28], instr_q[25:0], 2'b00};
         2'b10:   target = jr_target;
         default: target = pc_inc;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      buf_d   = buf_q;
      present = 1'b0;
      word    = buf_q;
      unique case (state_q)
         IDLE: begin
            if (redir) begin
               pc_d = target;
            end else begin
               addr_d  = pc_q;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (redir) begin
               pc_d    = target;
               state_d = imem.imem_ack ? IDLE : DRAIN;
            end else if (imem.imem_ack && deliver) begin
               present = 1'b1;
               word    = imem.imem_rdata;
               pc_d    = pc_inc;
               state_d = IDLE;
            end else if (imem.imem_ack) begin
               buf_d   = imem.imem_rdata;
               state_d = HOLD;
            end
         end
         // the in-flight word belongs to the old path; swallow it
         DRAIN: begin
            if (redir) begin
               pc_d = target;
            end
            if (imem.imem_ack) begin
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (redir) begin
               buf_d   = '0;
               pc_d    = target;
               state_d = IDLE;
            end else if (deliver) begin
               present = 1'b1;
               word    = buf_q;
               pc_d    = pc_inc;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      req_d = (state_d == WAIT) || (state_d == DRAIN);
   end

   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (IF_flush) begin
         instr_d = '0;
         valid_d = 1'b0;
      end else if (IF_ID_en && present) begin
         instr_d = word;
         pc4_d   = pc_inc;
         valid_d = 1'b1;
      end else if (IF_ID_en) begin
         instr_d = '0;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         buf_q   <= '0;
         req_q   <= 1'b0;
         instr_q <= '0;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         buf_q   <= buf_d;
         req_q   <= req_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = addr_q;

   assign IF_ID_instr    = instr_q;
   assign IF_ID_pc_plus4 = pc4_q;
   assign IF_ID_valid    = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: transaction-level fetch model plus directed scenarios.
// The imem responder returns addr|A000_0000 with configurable wait states.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_en = 1'b1;
   logic        IF_ID_en = 1'b1;
   logic        IF_flush = 1'b0;
   logic        pc_src = 1'b0;
   logic [1:0]  jump = 2'b11;
   logic [31:0] branch_target = '0;
   logic [31:0] jr_target = '0;
   logic [31:0] IF_ID_instr;
   logic [31:0] IF_ID_pc_plus4;
   logic        IF_ID_valid;

   if_stage_if imem ();

   if_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_en          (pc_en),
      .IF_ID_en       (IF_ID_en),
      .IF_flush       (IF_flush),
      .pc_src         (pc_src),
      .jump           (jump),
      .branch_target  (branch_target),
      .jr_target      (jr_target),
      .imem           (imem),
      .IF_ID_instr    (IF_ID_instr),
      .IF_ID_pc_plus4 (IF_ID_pc_plus4),
      .IF_ID_valid    (IF_ID_valid)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit mdl_on  = 1'b0;

   task automatic check32(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // ---------------- imem responder ----------------
   bit          mem_hold = 1'b0;
   logic [31:0] slow_addr = 32'h0000_0008;
   int          slow_cyc = 3;
   int          wcnt = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h1000_0004) return 32'h0800_0010;
      return a | 32'hA000_0000;
   endfunction

   initial begin
      imem.imem_ack   = 1'b0;
      imem.imem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (imem.imem_req && !mem_hold &&
             wcnt >= ((imem.imem_addr == slow_addr) ? slow_cyc : 0)) begin
            imem.imem_ack   = 1'b1;
            imem.imem_rdata = mem_word(imem.imem_addr);
            wcnt = 0;
         end else begin
            imem.imem_ack   = 1'b0;
            imem.imem_rdata = 32'hDEAD_BEEF;
            if (!imem.imem_req) wcnt = 0;
            else if (!mem_hold) wcnt++;
         end
      end
   end

   // ---------------- behavioural model ----------------
   // Tracks "fetch outstanding", "outstanding fetch is stale" and
   // "word parked"; a returned word is tagged with its own address.
   logic [31:0] m_pc, m_addr, m_buf, m_instr, m_pc4;
   bit          m_req, m_stale, m_have, m_valid;

   initial begin
      logic        redir, dlv, pres;
      logic [31:0] tgt, w;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            m_pc = 0; m_addr = 0; m_buf = 0;
            m_instr = 0; m_pc4 = 0;
            m_req = 0; m_stale = 0; m_have = 0; m_valid = 0;
         end else begin
            redir = pc_en && pc_src && (jump != 2'b11);
            dlv   = pc_en && IF_ID_en && !IF_flush;
            case (jump)
               2'b00:   tgt = branch_target;
               2'b01:   tgt = {m_pc4[31:28], m_instr[25:0], 2'b00};
               default: tgt = jr_target;
            endcase
            pres = 0;
            w = 0;
            if (!m_req && !m_have) begin
               if (redir) m_pc = tgt;
               else begin
                  m_addr = m_pc; m_req = 1; m_stale = 0;
               end
            end else if (m_req && !m_stale) begin
               if (redir) begin
                  m_pc = tgt;
                  if (imem.imem_ack) m_req = 0;
                  else m_stale = 1;
               end else if (imem.imem_ack) begin
                  m_req = 0;
                  if (dlv) begin
                     pres = 1; w = imem.imem_rdata; m_pc = m_addr + 4;
                  end else begin
                     m_have = 1; m_buf = imem.imem_rdata;
                  end
               end
            end else if (m_req) begin
               if (redir) m_pc = tgt;
               if (imem.imem_ack) begin
                  m_req = 0; m_stale = 0;
               end
            end else begin
               if (redir) begin
                  m_have = 0; m_pc = tgt;
               end else if (dlv) begin
                  m_have = 0; pres = 1; w = m_buf; m_pc = m_addr + 4;
               end
            end
            if (IF_flush) begin
               m_instr = 0; m_valid = 0;
            end else if (IF_ID_en && pres) begin
               m_instr = w; m_pc4 = m_addr + 4; m_valid = 1;
            end else if (IF_ID_en) begin
               m_instr = 0; m_valid = 0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (mdl_on) begin
            check32("req", {31'b0, imem.imem_req}, {31'b0, m_req});
            check32("addr", imem.imem_addr, m_addr);
            check32("valid", {31'b0, IF_ID_valid}, {31'b0, m_valid});
            check32("instr", IF_ID_instr, m_instr);
            check32("pc4", IF_ID_pc_plus4, m_pc4);
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic expect_load(input logic [31:0] ei, input logic [31:0] ep,
                              input int budget, output int gap);
      bit found = 0;
      gap = 0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         gap++;
         if (IF_ID_valid) found = 1;
      end
      if (!found) begin
         n_tests++;
         n_fail++;
         $display("FAIL load_timeout: no load of %h within %0d cycles",
                  ei, budget);
      end else begin
         check32("load_instr", IF_ID_instr, ei);
         check32("load_pc4", IF_ID_pc_plus4, ep);
      end
   endtask

   task automatic wait_req(input logic [31:0] ea, input int budget);
      bit found = 0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (imem.imem_req) found = 1;
      end
      if (!found) begin
         n_tests++;
         n_fail++;
         $display("FAIL req_timeout: no request for %h within %0d cycles",
                  ea, budget);
      end else begin
         check32("req_addr", imem.imem_addr, ea);
      end
   endtask

   task automatic redirect(input logic [1:0] j, input logic [31:0] bt,
                           input logic [31:0] jt, input logic fl);
      pc_src = 1'b1;
      jump = j;
      branch_target = bt;
      jr_target = jt;
      IF_flush = fl;
      @(posedge clk);
      #1;
      pc_src = 1'b0;
      jump = 2'b11;
      IF_flush = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scenarios ----------------
   initial begin
      int gap;
      #1 rst = 1'b0;
      #2;
      check32("rst_req", {31'b0, imem.imem_req}, 32'd0);
      check32("rst_addr", imem.imem_addr, 32'h0);
      check32("rst_valid", {31'b0, IF_ID_valid}, 32'd0);
      check32("rst_instr", IF_ID_instr, 32'h0);
      check32("rst_pc4", IF_ID_pc_plus4, 32'h0);
      mdl_on = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // zero-wait streaming, then 3 wait states at address 8
      expect_load(32'hA000_0000, 32'h4, 10, gap);
      expect_load(32'hA000_0004, 32'h8, 10, gap);
      check32("gap_zero_wait", gap, 2);
      expect_load(32'hA000_0008, 32'hC, 12, gap);
      check32("gap_3_waits", gap, 5);
      slow_addr = 32'hFFFF_FFF0;
      expect_load(32'hA000_000C, 32'h10, 10, gap);
      check32("gap_after_slow", gap, 2);

      // branch + flush while fetch of 0x10 is outstanding
      mem_hold = 1'b1;
      @(posedge clk);
      #1;
      redirect(2'b00, 32'h40, 32'h0, 1'b1);
      @(negedge clk);
      check32("drain_req", {31'b0, imem.imem_req}, 32'd1);
      check32("drain_addr", imem.imem_addr, 32'h10);
      check32("drain_valid", {31'b0, IF_ID_valid}, 32'd0);
      @(negedge clk);
      check32("drain_hold_addr", imem.imem_addr, 32'h10);
      mem_hold = 1'b0;
      expect_load(32'hA000_0040, 32'h44, 10, gap);

      // jr to a j instruction, then j using IF/ID contents
      redirect(2'b10, 32'h0, 32'h1000_0004, 1'b0);
      expect_load(32'h0800_0010, 32'h1000_0008, 10, gap);
      redirect(2'b01, 32'h0, 32'h0, 1'b0);
      wait_req(32'h1000_0040, 6);
      expect_load(32'hB000_0040, 32'h1000_0044, 6, gap);
      redirect(2'b10, 32'h0, 32'h200, 1'b0);
      wait_req(32'h200, 6);

      // ack under stall parks the word in the skid buffer
      IF_ID_en = 1'b0;
      pc_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check32("hold_req", {31'b0, imem.imem_req}, 32'd0);
         check32("hold_valid", {31'b0, IF_ID_valid}, 32'd0);
         check32("hold_pc4", IF_ID_pc_plus4, 32'h1000_0044);
      end
      IF_ID_en = 1'b1;
      pc_en = 1'b1;
      expect_load(32'hA000_0200, 32'h204, 4, gap);
      check32("hold_release_gap", gap, 1);
      wait_req(32'h204, 4);
      expect_load(32'hA000_0204, 32'h208, 4, gap);

      // PC wrap
      redirect(2'b10, 32'h0, 32'hFFFF_FFFC, 1'b0);
      expect_load(32'hFFFF_FFFC, 32'h0, 8, gap);

      // asynchronous reset in the middle of DRAIN
      IF_ID_en = 1'b0;
      mem_hold = 1'b1;
      @(posedge clk);
      #1;
      redirect(2'b00, 32'h300, 32'h0, 1'b0);
      #1;
      check32("pre_rst_req", {31'b0, imem.imem_req}, 32'd1);
      check32("pre_rst_valid", {31'b0, IF_ID_valid}, 32'd1);
      check32("pre_rst_instr", IF_ID_instr, 32'hFFFF_FFFC);
      #1 rst = 1'b0;
      #1;
      check32("async_rst_req", {31'b0, imem.imem_req}, 32'd0);
      check32("async_rst_valid", {31'b0, IF_ID_valid}, 32'd0);
      check32("async_rst_instr", IF_ID_instr, 32'h0);
      mem_hold = 1'b0;
      IF_ID_en = 1'b1;
      @(posedge clk);
      #1 rst = 1'b1;
      wait_req(32'h0, 6);
      expect_load(32'hA000_0000, 32'h4, 6, gap);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
